pipe_stage_ctrl_reg: RTL and testbench
======================================

Name: pipe_stage_ctrl_reg

Overview:
- Parametrised inter-stage pipeline register for the interrupt-capable pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds the following to a plain enable/flush register:
  - a valid bit;
  - a configurable per-bit keep-mask, so the PC field survives a flush and SEPC is never zeroed;
  - selectable stall/flush priority;
  - saturating flush and stall performance counters.
- Captures on the falling edge of clk, so the rising-edge register file and memories see stable stage outputs.

Parameters:
- WIDTH, 256, payload width in bits (>= PC_WIDTH).
- PC_WIDTH, 32, width of the PC field at payload bits [PC_WIDTH-1:0].
- KEEP_MASK, {(WIDTH-PC_WIDTH){0},(PC_WIDTH){1}}, per-bit mask. 1 = bit loads from in on flush; 0 = bit clears to 0 on flush.
- FLUSH_OVER_STALL, 1:
  - 1: flush acts even while stall is high.
  - 0: flush is ignored while stall is high (legacy enable-gated flush).
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  stage clock; state updates on negedge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold current contents.
- flush  in  1  squash the incoming instruction into a bubble, keeping masked fields.
- in_valid  in  1  incoming slot holds a real instruction.
- in  in  WIDTH  incoming payload.
- clr_cnt  in  1  synchronous clear of both counters.
- out  out  WIDTH  registered payload.
- out_valid  out  1  registered valid.
- out_pc  out  PC_WIDTH  equals out[PC_WIDTH-1:0]; used as the SEPC source.
- flush_cnt  out  CNT_WIDTH  number of flushes that acted.
- stall_cnt  out  CNT_WIDTH  number of held cycles.

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush): out=0, out_valid=0, flush_cnt=0, stall_cnt=0. First capture happens on the first negedge after rst deasserts.
- Derived terms:
  - do_flush = flush & (FLUSH_OVER_STALL | ~stall)
  - do_hold = stall & ~do_flush
- Priority at each negedge is rst > do_flush > do_hold > load.
  - do_flush: out <= in & KEEP_MASK; out_valid <= 0. Fields with mask 0 read 0; PC field = in PC.
  - do_hold: out and out_valid unchanged.
  - load (neither): out <= in; out_valid <= in_valid. Payload loads even when in_valid=0; consumers must gate on out_valid.
- Latency: 1 negedge from in to out. No combinational path from inputs to outputs.
- With FLUSH_OVER_STALL=0 and stall=flush=1: hold. The flush is lost, and the controller must re-assert flush after the stall.
- Counters:
  - flush_cnt increments on each do_flush edge.
  - stall_cnt increments on each do_hold edge.
  - Both saturate at all-ones with no wrap.
- clr_cnt=1 at an edge: both counters go to 0 and the increment in that edge is discarded. clr_cnt does not affect out or out_valid.
- X safety: with stall=flush=0, out_valid follows in_valid only. No state machine beyond the three-way capture mux plus the counters.

Decomposition:
- Package pipe_reg_pkg holds:
  - default PC_WIDTH, WIDTH and CNT_WIDTH constants;
  - function keep_pc_mask(width, pc_width), which builds the default KEEP_MASK;
  - priority-mode constants PRIO_FLUSH=1 and PRIO_STALL=0.
- One sub-module, sat_counter (params W; ports clk, rst, clr, inc, q). It is negedge, async-reset and saturating, and is instantiated twice.

Test Plan:
- Reset: assert rst mid-cycle while out=0xDEAD...BEEF and out_valid=1. Outputs are 0 immediately, before any clock edge, and both counters are 0.
- Load/latency: in=0x...0000_1234_0000_0040, in_valid=1, stall=flush=0. After one negedge, out equals in, out_valid=1, out_pc=0x40.
- Flush keeps PC: in upper bits all 1s, PC=0x0000_0080, flush=1. Result: out[WIDTH-1:32]=0, out_pc=0x80, out_valid=0, flush_cnt=1.
- Stall hold: hold stall=1 for 5 edges while in changes every cycle. out and out_valid stay constant and stall_cnt=5. Release stall, then the next edge loads the current in.
- Priority mode: stall=flush=1.
  - FLUSH_OVER_STALL=1: flush acts, stall_cnt unchanged, flush_cnt increments.
  - FLUSH_OVER_STALL=0: hold, stall_cnt increments, flush_cnt unchanged.
- Saturation/clear: with CNT_WIDTH=4, hold stall for 20 edges, so stall_cnt=15. Then clr_cnt=1 with stall=1: stall_cnt=0 after that edge and counts 1 on the next.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the inter-stage pipeline registers.
package pipe_reg_pkg;

    localparam int DEF_WIDTH     = 256;
    localparam int DEF_PC_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int MAX_WIDTH     = 1024;

    localparam bit PRIO_FLUSH = 1'b1;
    localparam bit PRIO_STALL = 1'b0;

    // Default keep-mask: ones over the PC field, zeros above it.
    function automatic logic [MAX_WIDTH-1:0] keep_pc_mask(input int width, input int pc_width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width && i < pc_width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Falling-edge saturating up-counter with synchronous clear and async reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over the increment that lands on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_ctrl_reg.sv
// Inter-stage pipeline register with valid bit, flush keep-mask, selectable
// stall/flush priority and saturating flush/stall counters. Captures on negedge.
module pipe_stage_ctrl_reg
    import pipe_reg_pkg::*;
#(
    parameter int             WIDTH            = DEF_WIDTH,
    parameter int             PC_WIDTH         = DEF_PC_WIDTH,
    parameter logic [WIDTH-1:0] KEEP_MASK      = WIDTH'(keep_pc_mask(WIDTH, PC_WIDTH)),
    parameter bit             FLUSH_OVER_STALL = PRIO_FLUSH,
    parameter int             CNT_WIDTH        = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in,
    input  logic                 clr_cnt,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    logic             do_flush;
    logic             do_hold;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    // With stall priority a coincident flush is dropped; the controller re-issues it.
    assign do_flush = flush & (FLUSH_OVER_STALL | ~stall);
    assign do_hold  = stall & ~do_flush;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (do_flush) begin
            out_d   = in & KEEP_MASK;
            valid_d = 1'b0;
        end else if (!do_hold) begin
            out_d   = in;
            valid_d = in_valid;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (do_flush),
        .q   (flush_cnt)
    );

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (do_hold),
        .q   (stall_cnt)
    );

    assign out       = out_q;
    assign out_valid = valid_q;
    assign out_pc    = out_q[PC_WIDTH-1:0];

endmodule

// File: tb/tb_pipe_stage_ctrl_reg.sv
// Bench for pipe_stage_ctrl_reg: flush-priority/16-bit-counter and
// stall-priority/4-bit-counter instances driven from shared directed stimulus.
module tb_pipe_stage_ctrl_reg;

    localparam int W  = 256;
    localparam int PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst      = 1'b1;
    logic         stall    = 1'b0;
    logic         flush    = 1'b0;
    logic         in_valid = 1'b0;
    logic         clr_cnt  = 1'b0;
    logic [W-1:0] in_data  = '0;

    logic [W-1:0]  o0, o1;
    logic          v0, v1;
    logic [PW-1:0] pc0, pc1;
    logic [15:0]   fc0, sc0;
    logic [3:0]    fc1, sc1;

    pipe_stage_ctrl_reg #(.WIDTH(W), .PC_WIDTH(PW), .FLUSH_OVER_STALL(1'b1), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in(in_data),
        .clr_cnt(clr_cnt), .out(o0), .out_valid(v0), .out_pc(pc0), .flush_cnt(fc0), .stall_cnt(sc0)
    );

    pipe_stage_ctrl_reg #(.WIDTH(W), .PC_WIDTH(PW), .FLUSH_OVER_STALL(1'b0), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in(in_data),
        .clr_cnt(clr_cnt), .out(o1), .out_valid(v1), .out_pc(pc1), .flush_cnt(fc1), .stall_cnt(sc1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour: index 0 = flush-priority/16-bit, index 1 = stall-priority/4-bit.
    logic [W-1:0] keep = {{(W-PW){1'b0}}, {PW{1'b1}}};
    logic [W-1:0] m_out [2];
    logic         m_v   [2];
    int           m_fc  [2];
    int           m_sc  [2];
    bit           fos   [2] = '{1'b1, 1'b0};
    int           cmax  [2] = '{65535, 15};

    always @(negedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_out[k] <= '0;
                m_v[k]   <= 1'b0;
                m_fc[k]  <= 0;
                m_sc[k]  <= 0;
            end else begin
                bit flush_acts;
                bit held;
                flush_acts = flush && (fos[k] || !stall);
                held       = stall && !flush_acts;
                if (flush_acts) begin
                    m_out[k] <= in_data & keep;
                    m_v[k]   <= 1'b0;
                end else if (!held) begin
                    m_out[k] <= in_data;
                    m_v[k]   <= in_valid;
                end
                if (clr_cnt) begin
                    m_fc[k] <= 0;
                    m_sc[k] <= 0;
                end else begin
                    if (flush_acts && m_fc[k] < cmax[k]) m_fc[k] <= m_fc[k] + 1;
                    if (held && m_sc[k] < cmax[k])       m_sc[k] <= m_sc[k] + 1;
                end
            end
        end
    end

    // Every rising edge sits mid-cycle between captures, so all outputs are settled.
    always @(posedge clk) begin
        check("cmp_out0",   o0,  m_out[0]);
        check("cmp_v0",     W'(v0),  W'(m_v[0]));
        check("cmp_pc0",    W'(pc0), W'(m_out[0][PW-1:0]));
        check("cmp_fc0",    W'(fc0), W'(m_fc[0]));
        check("cmp_sc0",    W'(sc0), W'(m_sc[0]));
        check("cmp_out1",   o1,  m_out[1]);
        check("cmp_v1",     W'(v1),  W'(m_v[1]));
        check("cmp_pc1",    W'(pc1), W'(m_out[1][PW-1:0]));
        check("cmp_fc1",    W'(fc1), W'(m_fc[1]));
        check("cmp_sc1",    W'(sc1), W'(m_sc[1]));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [W-1:0] beef = {8{32'hDEAD_BEEF}};
    logic [W-1:0] xv   = {8{32'hA5A5_5A5A}};
    logic [W-1:0] yv   = {8{32'h1357_9BDF}};
    logic [W-1:0] zv   = {8{32'h0F0F_00F0}};
    logic [W-1:0] pv   = {8{32'h2222_0100}};

    initial begin
        tick();
        check("rst_init_out", o0, '0);
        rst = 1'b0;

        in_data = beef; in_valid = 1'b1;
        tick();
        check("pre_rst_out", o0, beef);
        check("pre_rst_v", W'(v0), W'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_out0", o0, '0);
        check("async_rst_v0", W'(v0), W'(0));
        check("async_rst_out1", o1, '0);
        check("async_rst_cnt", W'({fc0, sc0}), '0);
        rst = 1'b0;

        in_data = W'(96'h0000_1234_0000_0040); in_valid = 1'b1;
        tick();
        check("load_out", o0, W'(96'h0000_1234_0000_0040));
        check("load_v", W'(v0), W'(1));
        check("load_pc", W'(pc0), W'(32'h40));

        in_data = {{(W-PW){1'b1}}, 32'h0000_0080}; flush = 1'b1;
        tick();
        check("flush_upper", o0[W-1:PW], '0);
        check("flush_pc", W'(pc0), W'(32'h80));
        check("flush_v", W'(v0), W'(0));
        check("flush_cnt0", W'(fc0), W'(1));
        check("flush_cnt1", W'(fc1), W'(1));
        flush = 1'b0;

        in_data = xv; in_valid = 1'b1;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data  = {8{$urandom}};
            in_valid = i[0];
            tick();
            check("stall_hold_out", o0, xv);
            check("stall_hold_v", W'(v0), W'(1));
        end
        check("stall_cnt0_5", W'(sc0), W'(5));
        check("stall_cnt1_5", W'(sc1), W'(5));
        stall = 1'b0; in_data = yv; in_valid = 1'b1;
        tick();
        check("release_load", o0, yv);

        in_data = zv; in_valid = 1'b0;
        tick();
        check("bubble_payload", o0, zv);
        check("bubble_v", W'(v0), W'(0));

        stall = 1'b1; flush = 1'b1; in_data = pv; in_valid = 1'b1;
        tick();
        check("prio_f_out", o0, W'(32'h2222_0100));
        check("prio_f_fc", W'(fc0), W'(2));
        check("prio_f_sc", W'(sc0), W'(5));
        check("prio_s_out", o1, zv);
        check("prio_s_fc", W'(fc1), W'(1));
        check("prio_s_sc", W'(sc1), W'(6));
        flush = 1'b0;

        for (int i = 0; i < 20; i++) tick();
        check("sat_sc1", W'(sc1), W'(15));
        check("sat_sc0", W'(sc0), W'(25));

        clr_cnt = 1'b1;
        tick();
        check("clr_sc1", W'(sc1), W'(0));
        check("clr_sc0", W'(sc0), W'(0));
        check("clr_fc0", W'(fc0), W'(0));
        check("clr_keeps_out", o1, zv);
        clr_cnt = 1'b0;
        tick();
        check("post_clr_sc1", W'(sc1), W'(1));
        check("post_clr_sc0", W'(sc0), W'(1));

        #2 rst = 1'b1;
        #1;
        check("rst_mid_stall_sc0", W'(sc0), W'(0));
        check("rst_mid_stall_out1", o1, '0);
        rst = 1'b0; stall = 1'b0; in_data = yv; in_valid = 1'b1;
        tick();
        check("after_rst_load", o1, yv);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
